// File: rtl/lbp_pkg.sv
// Shared types and helpers for the LBP histogram block: FSM states, raster geometry and
// the raster-order successor function.
package lbp_pkg;

    typedef enum logic [1:0] {CLEAR, ACCUM, FLUSH, DRAIN} hist_state_e;

    localparam int IMG_FIRST      = 1;
    localparam int IMG_LAST       = 126;
    localparam int ADDR_W         = 14;
    localparam int UNIFORM_BINS   = 59;
    localparam int NONUNIFORM_BIN = 58;

    // Address of the pixel following addr in raster order; X wraps to IMG_FIRST.
    function automatic logic [ADDR_W-1:0] next_raster_addr(input logic [ADDR_W-1:0] addr,
                                                           input int img_last);
        logic [6:0] x;
        logic [6:0] y;
        x = addr[6:0];
        y = addr[13:7];
        if (int'(x) >= img_last) begin
            x = 7'(IMG_FIRST);
            y = y + 7'd1;
        end else begin
            x = x + 7'd1;
        end
        return {y, x};
    endfunction

endpackage

// File: rtl/lbp_bin_map.sv
// Maps an LBP code to a histogram bin index. Define HIST_UNIFORM_EN to select the
// 59-bin uniform-LBP mapping instead of the default top-bits shift mapping.
module lbp_bin_map
    import lbp_pkg::*;
#(
    parameter int BINS_LOG2 = 8
) (
    input  logic [7:0] lbp_data,
    output logic [7:0] bin
);

`ifdef HIST_UNIFORM_EN
    // Uniform codes (<= 2 circular transitions) are numbered in ascending code order.
    function automatic logic [2047:0] build_uniform_lut();
        logic [2047:0] lut;
        logic [7:0]    c;
        int            idx;
        lut = '0;
        idx = 0;
        for (int i = 0; i < 256; i++) begin
            c = 8'(i);
            if ($countones(c ^ {c[0], c[7:1]}) <= 2) begin
                lut[i*8 +: 8] = 8'(idx);
                idx++;
            end else begin
                lut[i*8 +: 8] = 8'(NONUNIFORM_BIN);
            end
        end
        return lut;
    endfunction

    localparam logic [2047:0] UNIFORM_LUT = build_uniform_lut();

    assign bin = UNIFORM_LUT[{lbp_data, 3'b000} +: 8];
`else
    assign bin = 8'(lbp_data >> (8 - BINS_LOG2));
`endif

endmodule

// File: rtl/lbp_hist.sv
// Per-frame LBP code histogram with raster-order checking and a valid/ready bin drain.
// HIST_UNIFORM_EN selects 59 uniform-LBP bins in place of 2**BINS_LOG2 shift bins.
module lbp_hist
    import lbp_pkg::*;
#(
    parameter int BINS_LOG2 = 8,
    parameter int CNT_W     = 14,
    parameter int IMG_LAST  = lbp_pkg::IMG_LAST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [7:0]        lbp_data,
    input  logic              finish,
    output logic              hist_busy,
    output logic              hist_valid,
    input  logic              hist_ready,
    output logic [7:0]        hist_bin,
    output logic [CNT_W-1:0]  hist_count,
    output logic              hist_last,
    output logic              hist_done,
    output logic              hist_err
);

`ifdef HIST_UNIFORM_EN
    localparam int NBINS = UNIFORM_BINS;
`else
    localparam int NBINS = 2 ** BINS_LOG2;
`endif
    localparam int                IDX_W      = (NBINS > 1) ? $clog2(NBINS) : 1;
    localparam logic [7:0]        LAST_BIN   = 8'(NBINS - 1);
    localparam logic [ADDR_W-1:0] FIRST_ADDR = {7'(IMG_FIRST), 7'(IMG_FIRST)};

    hist_state_e       state;
    logic [7:0]        clr_ptr;
    logic              flush_cnt;
    logic [ADDR_W-1:0] exp_addr;
    logic              s1_valid;
    logic [7:0]        s1_bin;
    logic [7:0]        map_bin;
    logic [7:0]        next_bin;
    logic              handshake;
    logic [CNT_W-1:0]  mem [NBINS];

    lbp_bin_map #(
        .BINS_LOG2(BINS_LOG2)
    ) u_bin_map (
        .lbp_data(lbp_data),
        .bin     (map_bin)
    );

    assign handshake = hist_valid & hist_ready;
    assign next_bin  = hist_bin + 8'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= CLEAR;
            clr_ptr    <= '0;
            flush_cnt  <= 1'b0;
            exp_addr   <= FIRST_ADDR;
            s1_valid   <= 1'b0;
            s1_bin     <= '0;
            hist_busy  <= 1'b0;
            hist_valid <= 1'b0;
            hist_bin   <= '0;
            hist_count <= '0;
            hist_last  <= 1'b0;
            hist_done  <= 1'b0;
            hist_err   <= 1'b0;
        end else begin
            s1_valid  <= 1'b0;
            hist_done <= 1'b0;
            if (lbp_valid && state != ACCUM) begin
                hist_err <= 1'b1;
            end
            unique case (state)
                CLEAR: begin
                    hist_busy <= 1'b1;
                    clr_ptr   <= clr_ptr + 8'd1;
                    if (clr_ptr == LAST_BIN) begin
                        state     <= ACCUM;
                        clr_ptr   <= '0;
                        hist_busy <= 1'b0;
                        hist_err  <= 1'b0;
                        exp_addr  <= FIRST_ADDR;
                    end
                end
                ACCUM: begin
                    if (lbp_valid) begin
                        s1_valid <= 1'b1;
                        s1_bin   <= map_bin;
                        if (lbp_addr != exp_addr) begin
                            hist_err <= 1'b1;
                        end
                        exp_addr <= next_raster_addr(lbp_addr, IMG_LAST);
                    end
                    if (finish) begin
                        state     <= FLUSH;
                        flush_cnt <= 1'b0;
                        hist_busy <= 1'b1;
                    end
                end
                FLUSH: begin
                    flush_cnt <= 1'b1;
                    // The final S2 write lands on the first FLUSH edge, so bin 0 is current here.
                    if (flush_cnt) begin
                        state      <= DRAIN;
                        hist_valid <= 1'b1;
                        hist_bin   <= '0;
                        hist_count <= mem[0];
                        hist_last  <= (LAST_BIN == 8'd0);
                    end
                end
                DRAIN: begin
                    if (handshake) begin
                        if (hist_last) begin
                            state      <= CLEAR;
                            clr_ptr    <= '0;
                            hist_valid <= 1'b0;
                            hist_bin   <= '0;
                            hist_count <= '0;
                            hist_last  <= 1'b0;
                            hist_done  <= 1'b1;
                        end else begin
                            hist_bin   <= next_bin;
                            hist_count <= mem[next_bin[IDX_W-1:0]];
                            hist_last  <= (next_bin == LAST_BIN);
                        end
                    end
                end
            endcase
        end
    end

    // Bin storage is not reset; CLEAR initialises it before any frame is accumulated.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_ptr[IDX_W-1:0]] <= '0;
        end else if (s1_valid) begin
            if (mem[s1_bin[IDX_W-1:0]] != {CNT_W{1'b1}}) begin
                mem[s1_bin[IDX_W-1:0]] <= mem[s1_bin[IDX_W-1:0]] + 1'b1;
            end
        end
    end

endmodule

// File: doc/lbp_hist.md
Name: lbp_hist

Overview:
- Downstream consumer of the LBP stage: snoops the LBP write-back bus (lbp_valid/lbp_addr/lbp_data/finish) and accumulates a per-frame histogram of LBP codes.
- On the frame-end finish pulse, drains all bins over a valid/ready stream, then self-clears for the next frame.
- Also checks that LBP results arrive in raster order over the 126x126 interior window and flags violations.

Parameters:
- BINS_LOG2, 8, histogram bins = 2**BINS_LOG2 (1..8); bin index = lbp_data >> (8-BINS_LOG2)
- CNT_W, 14, bin counter width; counts saturate at 2**CNT_W-1
- IMG_LAST, 126, last valid X/Y coordinate; first is 1

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- lbp_valid  in  1  one-cycle strobe, LBP result present
- lbp_addr  in  14  {Y[6:0],X[6:0]} of the result
- lbp_data  in  8  LBP code
- finish  in  1  one-cycle frame-end strobe from the LBP stage
- hist_busy  out  1  high in CLEAR, FLUSH and DRAIN; lbp_valid dropped while high
- hist_valid  out  1  bin output valid
- hist_ready  in  1  sink accepts the bin when hist_valid & hist_ready
- hist_bin  out  8  bin index, zero-extended
- hist_count  out  CNT_W  bin count
- hist_last  out  1  high with the final bin
- hist_done  out  1  one-cycle pulse on acceptance of the last bin
- hist_err  out  1  sticky raster-order/drop error, cleared on entry to ACCUM

Behaviour:
- Reset values: all outputs 0. FSM state is CLEAR, clear pointer 0, expected address {1,1}.
- Storage: register array of NBINS x CNT_W. Its contents are undefined after reset until CLEAR completes.
- CLEAR: writes 0 to one bin per cycle, index 0..NBINS-1, so it takes NBINS cycles. hist_busy=1. Then goes to ACCUM and sets hist_err=0.
- ACCUM, 2-stage pipeline:
  - S1 registers the bin index and valid.
  - S2 does read-modify-write: count+1, saturating.
  - A bin reflects a sample 2 cycles after the lbp_valid edge.
  - Back-to-back samples to the same bin count correctly: S2 reads the array after the previous write commits.
- Raster check, in ACCUM on each lbp_valid:
  - If lbp_addr != expected, set hist_err. Then set expected = lbp_addr+1 in raster order: X wraps IMG_LAST->1 and Y increments.
  - The sample is still counted either way.
- finish in ACCUM goes to FLUSH, which lasts 2 cycles so the pipeline empties. Then DRAIN with pointer 0.
- lbp_valid in the same cycle as finish is counted.
- lbp_valid during CLEAR, FLUSH or DRAIN is dropped and sets hist_err.
- finish outside ACCUM is ignored.
- DRAIN:
  - hist_valid=1, hist_bin=pointer, hist_count=array[pointer].
  - Outputs are held stable while hist_ready=0.
  - On handshake the pointer increments.
  - hist_last=1 when pointer=NBINS-1.
  - On the last handshake, hist_done pulses for 1 cycle and the FSM returns to CLEAR.
- Async reset mid-frame or mid-drain aborts immediately to the reset state. There is no partial output.
- A frame with zero samples drains NBINS bins, all count 0.

Optional Feature:
- Macro HIST_UNIFORM_EN.
- When defined, the code maps to 59 uniform-LBP bins and BINS_LOG2 is ignored:
  - A uniform code has at most 2 circular 0/1 transitions; there are 58 of them.
  - Each uniform code gets index 0..57 in ascending code value, so 0x00->0, 0x01->1, 0x02->2, 0x03->3, 0x04->4, 0x06->5 ... 0xFF->57.
  - All non-uniform codes map to 58.
  - DRAIN emits 59 bins.
- When undefined, the shift mapping applies.

Decomposition:
- Package lbp_pkg:
  - FSM state enum: CLEAR, ACCUM, FLUSH, DRAIN.
  - IMG_FIRST=1 and IMG_LAST=126.
  - ADDR_W=14.
  - Function next_raster_addr.
- Sub-module lbp_bin_map, purely combinational: lbp_data in, bin index out. Contains the shift mapping or, under HIST_UNIFORM_EN, the uniform LUT.

Test Plan:
- Reset, then wait NBINS cycles.
  - hist_busy falls at cycle 256, hist_err=0.
  - Pulse finish: 256 bins drained, all 0, hist_last on bin 255, hist_done 1 cycle.
- Full 126x126 frame in raster order, all codes 0x5A, then finish.
  - bin 90 count 15876, all others 0, hist_err=0.
- Two back-to-back lbp_valid pulses with codes 7,7, plus a code 200.
  - bin7=2, bin200=1 at drain.
- Sample at {1,1}, then {1,3}.
  - hist_err=1 after the 2nd sample; both counted.
- During DRAIN, hold hist_ready=0 for 5 cycles at bin 3.
  - hist_bin/hist_count stable. lbp_valid pulse in DRAIN sets hist_err; counts unchanged.
- HIST_UNIFORM_EN with codes 0x06, 0x05, 0xFF.
  - bins 5=1, 58=1, 57=1; 59 bins drained.
